logbar_scheduler: RTL

Frame scheduler that shares the single FFT log-bar converter between the left and right FFT magnitude buffers. On each channel's frame request it walks all bins of that channel: read magnitude, start the converter, wait for its completion, write the 7-bit bar height into the display bar RAM. It sits between the two FFT cores' magnitude RAMs and the display refresh logic. Arbitration is round-robin per frame, and a watchdog guards against a hung converter.

---
 rtl/logbar_scheduler_pkg.sv | 26 ++
 rtl/logbar_scheduler_rr_arb2.sv | 54 +++++
 rtl/logbar_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/logbar_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : logbar_scheduler_pkg
//  Purpose  : Shared types and constants for the log-bar frame scheduler:
//             FSM state encoding, channel identifiers and bar width.
//  Revision : 1.0  initial release
// ============================================================================
package logbar_scheduler_pkg;

   // Per-bin walk: read magnitude, latch it, start converter, wait, write bar.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_LATCH = 3'd2,
      ST_START = 3'd3,
      ST_WAIT  = 3'd4,
      ST_WR    = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   localparam logic CH_L  = 1'b0;
   localparam logic CH_R  = 1'b1;
   localparam int   BAR_W = 7;

endpackage
`default_nettype wire

// File: rtl/logbar_scheduler_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-requester round-robin arbiter. Holds the pending frame
//             flags for the left/right channels and the last-served channel.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
   import logbar_scheduler_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic [1:0] req,       // bit 0 = left, bit 1 = right
   input  logic       grant_en,  // scheduler is idle and can accept a frame
   output logic       grant,
   output logic       ch
);

   logic [1:0] pend_q, pend_d;
   logic       last_ch_q, last_ch_d;

   // Choose a channel; a tie goes to the channel not served last. The last
   // channel is recorded at grant time: no further grant can happen before
   // the frame ends, so this matches recording it when the frame completes.
   always_comb begin
      grant     = grant_en & (|pend_q);
      if (pend_q == 2'b11) begin
         ch = ~last_ch_q;
      end else begin
         ch = pend_q[1] ? CH_R : CH_L;
      end
      pend_d    = pend_q;
      last_ch_d = last_ch_q;
      if (grant) begin
         pend_d[ch] = 1'b0;
         last_ch_d  = ch;
      end
      // A request arriving with its own grant must survive the clear.
      pend_d = pend_d | req;
   end

   // Pending flags and last-served channel; lastCh starts at R so L wins the first tie.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pend_q    <= 2'b00;
         last_ch_q <= CH_R;
      end else begin
         pend_q    <= pend_d;
         last_ch_q <= last_ch_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/logbar_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : logbar_scheduler
//  Purpose  : Shares one FFT log-bar converter between the left and right
//             magnitude buffers. Walks every bin of a granted channel, runs
//             the converter with a watchdog, writes bar heights to bar RAM.
//  Revision : 1.0  initial release
// ============================================================================
module logbar_scheduler
   import logbar_scheduler_pkg::*;
#(
   parameter int BW_INPUT    = 18,
   parameter int N_BINS_LOG2 = 5,
   parameter int TIMEOUT     = 40
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   ReqL,
   input  logic                   ReqR,
   output logic                   AckL,
   output logic                   AckR,
   output logic                   MagRe,
   output logic [N_BINS_LOG2:0]   MagAddr,
   input  logic [BW_INPUT-1:0]    MagData,
   output logic                   ConvStart,
   output logic [BW_INPUT-1:0]    ConvIn,
   input  logic [BAR_W-1:0]       ConvOut,
   input  logic                   ConvEnd,
   output logic                   BarWe,
   output logic [N_BINS_LOG2:0]   BarAddr,
   output logic [BAR_W-1:0]       BarData,
   output logic                   Busy,
   output logic                   ErrTimeout
);

   localparam int                     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [N_BINS_LOG2-1:0] BIN_LAST = '1;

   state_t                  state_q, state_d;
   logic                    ch_q, ch_d;
   logic [N_BINS_LOG2-1:0]  bin_q, bin_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    mag_re_q, mag_re_d;
   logic [N_BINS_LOG2:0]    mag_addr_q, mag_addr_d;
   logic                    conv_start_q, conv_start_d;
   logic [BW_INPUT-1:0]     conv_in_q, conv_in_d;
   logic                    bar_we_q, bar_we_d;
   logic [N_BINS_LOG2:0]    bar_addr_q, bar_addr_d;
   logic [BAR_W-1:0]        bar_data_q, bar_data_d;
   logic                    busy_q, busy_d;
   logic                    ack_l_q, ack_l_d;
   logic                    ack_r_q, ack_r_d;
   logic                    err_q, err_d;

   logic                    arb_grant;
   logic                    arb_ch;

   rr_arb2 u_arb (
      .Clock    (Clock),
      .Reset    (Reset),
      .req      ({ReqR, ReqL}),
      .grant_en (state_q == ST_IDLE),
      .grant    (arb_grant),
      .ch       (arb_ch)
   );

   // Next-state logic; outputs are derived from the next state so every port is a flop.
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      bin_d      = bin_q;
      cnt_d      = cnt_q;
      conv_in_d  = conv_in_q;
      bar_data_d = bar_data_q;
      err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_grant) begin
               state_d = ST_RD;
               ch_d    = arb_ch;
               bin_d   = '0;
            end
         end
         ST_RD:    state_d = ST_LATCH;
         ST_LATCH: begin
            conv_in_d = MagData;
            state_d   = ST_START;
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (ConvEnd) begin
               bar_data_d = ConvOut;
               state_d    = ST_WR;
            end else if (cnt_q == CNT_LAST) begin
               // Hung converter: write an empty bar and move on.
               bar_data_d = '0;
               err_d      = 1'b1;
               state_d    = ST_WR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WR: begin
            if (bin_q == BIN_LAST) begin
               state_d = ST_DONE;
            end else begin
               bin_d   = bin_q + N_BINS_LOG2'(1);
               state_d = ST_RD;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      mag_re_d     = (state_d == ST_RD);
      conv_start_d = (state_d == ST_START);
      bar_we_d     = (state_d == ST_WR);
      busy_d       = (state_d != ST_IDLE);
      ack_l_d      = (state_d == ST_DONE) && (ch_d == CH_L);
      ack_r_d      = (state_d == ST_DONE) && (ch_d == CH_R);
      mag_addr_d   = (state_d == ST_RD) ? {ch_d, bin_d} : mag_addr_q;
      bar_addr_d   = (state_d == ST_WR) ? {ch_d, bin_d} : bar_addr_q;
   end

   // State, counters and registered outputs; reset abandons any frame in flight.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         ch_q         <= CH_L;
         bin_q        <= '0;
         cnt_q        <= '0;
         mag_re_q     <= 1'b0;
         mag_addr_q   <= '0;
         conv_start_q <= 1'b0;
         conv_in_q    <= '0;
         bar_we_q     <= 1'b0;
         bar_addr_q   <= '0;
         bar_data_q   <= '0;
         busy_q       <= 1'b0;
         ack_l_q      <= 1'b0;
         ack_r_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         bin_q        <= bin_d;
         cnt_q        <= cnt_d;
         mag_re_q     <= mag_re_d;
         mag_addr_q   <= mag_addr_d;
         conv_start_q <= conv_start_d;
         conv_in_q    <= conv_in_d;
         bar_we_q     <= bar_we_d;
         bar_addr_q   <= bar_addr_d;
         bar_data_q   <= bar_data_d;
         busy_q       <= busy_d;
         ack_l_q      <= ack_l_d;
         ack_r_q      <= ack_r_d;
         err_q        <= err_d;
      end
   end

   assign MagRe      = mag_re_q;
   assign MagAddr    = mag_addr_q;
   assign ConvStart  = conv_start_q;
   assign ConvIn     = conv_in_q;
   assign BarWe      = bar_we_q;
   assign BarAddr    = bar_addr_q;
   assign BarData    = bar_data_q;
   assign Busy       = busy_q;
   assign AckL       = ack_l_q;
   assign AckR       = ack_r_q;
   assign ErrTimeout = err_q;

endmodule
`default_nettype wire
